// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and command constants for the SPI readout target.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_STAT,
    ST_DATA,
    ST_DRAIN
  } spi_state_t;

  localparam logic [7:0] CMD_READ_DEFAULT   = 8'hA5;
  localparam logic [7:0] CMD_STATUS_DEFAULT = 8'h0F;
  localparam int         STATUS_W           = 8;

endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: STAGES-deep synchronizer for one asynchronous SPI pin, with
// single-clk rise/fall pulses taken from the synchronized level and its delayed copy.
module spi_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic asyn_resetn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  // Metastability chain plus one extra copy used only for edge detection.
  always_ff @(posedge clk or negedge asyn_resetn) begin
    if (!asyn_resetn) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_readout_tx.sv
// spi_readout_tx: SPI mode-0 target that returns a status byte or streams
// buffer words on MISO after a one-byte command.
// Optional macro SPI_PARITY_EN: append an odd-parity bit after each data word.
module spi_readout_tx
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         DW          = 24,
  parameter logic [7:0] CMD_READ    = CMD_READ_DEFAULT,
  parameter logic [7:0] CMD_STATUS  = CMD_STATUS_DEFAULT
) (
  input  logic          clk,
  input  logic          asyn_resetn,
  input  logic          spi_csn,
  input  logic          spi_sclk,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  input  logic [DW-1:0] buf_data,
  input  logic          buf_int_raw,
  input  logic          buf_int_peak,
  output logic          buf_odstart,
  output logic          busy
);

`ifdef SPI_PARITY_EN
  localparam logic [4:0] FRAME_BITS = 5'(DW + 1);
`else
  localparam logic [4:0] FRAME_BITS = 5'(DW);
`endif

  logic cs_rise, cs_fall, cs_level_unused;
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic mosi, mosi_rise_unused, mosi_fall_unused;

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .asyn_resetn(asyn_resetn), .din(spi_csn),
    .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall));

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .asyn_resetn(asyn_resetn), .din(spi_sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall));

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .asyn_resetn(asyn_resetn), .din(spi_mosi),
    .level(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  spi_state_t          state_reg, state_next, cmd_target_reg;
  logic [4:0]          bit_cnt_reg;
  logic [7:0]          cmd_sr_reg;
  logic [DW-1:0]       shift_reg;
  logic                miso_reg;
  logic                odstart_reg;
  logic                cmd_shift, word_load, stat_load, shift_step;
  logic [7:0]          cmd_byte;
  logic [STATUS_W-1:0] status;
`ifdef SPI_PARITY_EN
  logic                parity_reg;
`endif

  assign cmd_byte = {cmd_sr_reg[6:0], mosi};
  assign status   = {{(STATUS_W-2){1'b0}}, buf_int_peak, buf_int_raw};

  // FSM state register.
  always_ff @(posedge clk or negedge asyn_resetn) begin
    if (!asyn_resetn) state_reg <= ST_IDLE;
    else              state_reg <= state_next;
  end

  // Next-state and datapath strobes; CS rise overrides anything else this clk.
  always_comb begin
    state_next = state_reg;
    cmd_shift  = 1'b0;
    word_load  = 1'b0;
    stat_load  = 1'b0;
    shift_step = 1'b0;
    case (state_reg)
      ST_IDLE: if (cs_fall) state_next = ST_CMD;
      ST_CMD: begin
        if (sclk_rise && bit_cnt_reg != 5'd8) cmd_shift = 1'b1;
        if (sclk_fall && bit_cnt_reg == 5'd8) begin
          state_next = cmd_target_reg;
          word_load  = (cmd_target_reg == ST_DATA);
          stat_load  = (cmd_target_reg == ST_STAT);
        end
      end
      ST_STAT: if (sclk_fall) shift_step = 1'b1;
      ST_DATA: begin
        if (sclk_fall) begin
          if (bit_cnt_reg == FRAME_BITS) word_load = 1'b1;
          else                           shift_step = 1'b1;
        end
      end
      default: ;
    endcase
    if (cs_rise) begin
      state_next = ST_IDLE;
      cmd_shift  = 1'b0;
      word_load  = 1'b0;
      stat_load  = 1'b0;
      shift_step = 1'b0;
    end
  end

  // Command capture, word/status loading and MISO shifting on SCLK edges.
  always_ff @(posedge clk or negedge asyn_resetn) begin
    if (!asyn_resetn) begin
      bit_cnt_reg    <= '0;
      cmd_sr_reg     <= '0;
      shift_reg      <= '0;
      miso_reg       <= 1'b0;
      odstart_reg    <= 1'b0;
      cmd_target_reg <= ST_IDLE;
`ifdef SPI_PARITY_EN
      parity_reg     <= 1'b0;
`endif
    end else begin
      // Advance strobe follows a data load by one clk, only if the buffer had something.
      odstart_reg <= word_load & (buf_int_raw | buf_int_peak);
      if (cs_rise) begin
        miso_reg <= 1'b0;
      end else if (state_reg == ST_IDLE && cs_fall) begin
        bit_cnt_reg <= '0;
        cmd_sr_reg  <= '0;
        shift_reg   <= '0;
        miso_reg    <= 1'b0;
      end else if (cmd_shift) begin
        cmd_sr_reg  <= cmd_byte;
        bit_cnt_reg <= bit_cnt_reg + 5'd1;
        if (bit_cnt_reg == 5'd7) begin
          if (cmd_byte == CMD_STATUS)    cmd_target_reg <= ST_STAT;
          else if (cmd_byte == CMD_READ) cmd_target_reg <= ST_DATA;
          else                           cmd_target_reg <= ST_DRAIN;
        end
      end else if (word_load) begin
        // The first bit of the new word goes out on this same falling edge.
        miso_reg    <= buf_data[DW-1];
        shift_reg   <= {buf_data[DW-2:0], 1'b0};
        bit_cnt_reg <= 5'd1;
`ifdef SPI_PARITY_EN
        parity_reg  <= ~^buf_data;
`endif
      end else if (stat_load) begin
        miso_reg    <= status[STATUS_W-1];
        shift_reg   <= {status[STATUS_W-2:0], {(DW-STATUS_W+1){1'b0}}};
        bit_cnt_reg <= 5'd1;
      end else if (shift_step) begin
        miso_reg  <= shift_reg[DW-1];
`ifdef SPI_PARITY_EN
        if (state_reg == ST_DATA && bit_cnt_reg == 5'(DW)) miso_reg <= parity_reg;
`endif
        shift_reg <= {shift_reg[DW-2:0], 1'b0};
        if (bit_cnt_reg != FRAME_BITS) bit_cnt_reg <= bit_cnt_reg + 5'd1;
      end
    end
  end

  assign spi_miso    = miso_reg;
  assign buf_odstart = odstart_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign spi_miso_oe = busy;

endmodule

// File: tb/tb_spi_readout_tx.sv
// tb_spi_readout_tx: SPI host driver, sniffing monitor with an expected-frame
// scoreboard, and a FIFO-style buffer model that advances on each odstart pulse.
`timescale 1ns/1ps
module tb_spi_readout_tx;
  import spi_pkg::*;

  localparam int DW   = 24;
  localparam int SYNC = 2;
  localparam int HALF = 6;   // SCLK half period in clk cycles (SCLK = clk/12)
`ifdef SPI_PARITY_EN
  localparam int FRAME = DW + 1;
`else
  localparam int FRAME = DW;
`endif

  logic          clk = 1'b0;
  logic          asyn_resetn = 1'b0;
  logic          spi_csn = 1'b1;
  logic          spi_sclk = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_miso, spi_miso_oe, buf_odstart, busy;
  logic [DW-1:0] buf_data = '0;
  logic          buf_int_raw = 1'b0;
  logic          buf_int_peak = 1'b0;

  always #5 clk = ~clk;

  spi_readout_tx #(.SYNC_STAGES(SYNC), .DW(DW)) dut (
    .clk(clk), .asyn_resetn(asyn_resetn),
    .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .buf_data(buf_data), .buf_int_raw(buf_int_raw), .buf_int_peak(buf_int_peak),
    .buf_odstart(buf_odstart), .busy(busy));

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [31:0]   exp_q[$];
  logic [DW-1:0] buf_q[$];
  int            od_pulses = 0;
  int            od_run    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference frame as the host sees it: word MSB first, then odd parity if enabled.
  function automatic logic [31:0] frame_of(input logic [DW-1:0] w);
`ifdef SPI_PARITY_EN
    return {7'b0, w, ~^w};
`else
    return {8'b0, w};
`endif
  endfunction

  // Buffer model: pops one word per odstart pulse; presents zeros when no interrupt.
  always @(negedge clk) begin
    if (buf_odstart) begin
      if (od_run == 0) begin
        od_pulses++;
        if (buf_q.size() > 0) void'(buf_q.pop_front());
      end
      od_run++;
    end else if (od_run > 0) begin
      check("odstart_width", 32'(od_run), 32'd1);
      od_run = 0;
    end
    buf_data = ((buf_int_raw | buf_int_peak) && buf_q.size() > 0) ? buf_q[0] : '0;
  end

  // Monitor: sniffs the bus on SCLK rises, rebuilds frames and scores them.
  initial begin : monitor
    int          rx_n, fb, flen;
    logic [7:0]  cmd;
    logic [31:0] acc;
    rx_n = 0; fb = 0; flen = STATUS_W; cmd = '0; acc = '0;
    forever begin
      @(posedge spi_sclk or posedge spi_csn);
      if (spi_csn) begin
        rx_n = 0; fb = 0; acc = '0;
      end else if (rx_n < 8) begin
        check("miso_during_cmd", {31'b0, spi_miso}, 32'd0);
        cmd = {cmd[6:0], spi_mosi};
        rx_n++;
        if (rx_n == 8) flen = (cmd == CMD_READ_DEFAULT) ? FRAME : STATUS_W;
      end else begin
        acc = {acc[30:0], spi_miso};
        fb++;
        if (fb == flen) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL frame_unexpected: got %h, expected no frame", acc);
          end else begin
            check("miso_frame", acc, exp_q.pop_front());
          end
          fb = 0; acc = '0;
        end
      end
    end
  end

  // Host: CS low, command byte then nbits clocks; final SCLK fall optionally coincides with CS rise.
  task automatic spi_clock(input logic [7:0] cmd, input int nbits, input bit raise_cs);
    spi_csn = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 8 + nbits; i++) begin
      if (i < 8) spi_mosi = cmd[7-i];
      else       spi_mosi = 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
      if (raise_cs && i == 8 + nbits - 1) spi_csn = 1'b1;
    end
    spi_mosi = 1'b0;
  endtask

  task automatic do_read(input int nwords, input logic raw, input logic peak);
    int p0;
    buf_int_raw = raw; buf_int_peak = peak;
    repeat (2) @(negedge clk);
    for (int k = 0; k < nwords; k++)
      exp_q.push_back(frame_of((raw | peak) ? buf_q[k] : '0));
    p0 = od_pulses;
    spi_clock(CMD_READ_DEFAULT, nwords * FRAME, 1'b1);
    repeat (SYNC + 4) @(negedge clk);
    check("read_odstart_count", 32'(od_pulses - p0), (raw | peak) ? 32'(nwords) : 32'd0);
    check("read_busy_after", {31'b0, busy}, 32'd0);
    check("read_frames_drained", 32'(exp_q.size()), 32'd0);
    $display("read   words=%0d raw=%b peak=%b pulses=%0d", nwords, raw, peak, od_pulses - p0);
  endtask

  task automatic do_status(input logic raw, input logic peak, input int nbytes);
    int p0;
    buf_int_raw = raw; buf_int_peak = peak;
    repeat (2) @(negedge clk);
    exp_q.push_back({30'b0, peak, raw});
    for (int k = 1; k < nbytes; k++) exp_q.push_back(32'd0);
    p0 = od_pulses;
    spi_clock(CMD_STATUS_DEFAULT, nbytes * 8, 1'b1);
    repeat (SYNC + 4) @(negedge clk);
    check("status_no_odstart", 32'(od_pulses - p0), 32'd0);
    check("status_frames_drained", 32'(exp_q.size()), 32'd0);
    $display("status raw=%b peak=%b bytes=%0d", raw, peak, nbytes);
  endtask

  task automatic do_bad(input logic [7:0] cmd, input int nbytes);
    int p0;
    for (int k = 0; k < nbytes; k++) exp_q.push_back(32'd0);
    p0 = od_pulses;
    spi_clock(cmd, nbytes * 8, 1'b0);
    repeat (2) @(negedge clk);
    check("bad_busy_during", {31'b0, busy}, 32'd1);
    check("bad_oe_during", {31'b0, spi_miso_oe}, 32'd1);
    spi_csn = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    check("bad_busy_drop", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("bad_no_odstart", 32'(od_pulses - p0), 32'd0);
    check("bad_frames_drained", 32'(exp_q.size()), 32'd0);
    $display("bad    cmd=%h bytes=%0d", cmd, nbytes);
  endtask

  task automatic refill(input int n);
    while (buf_q.size() < n) buf_q.push_back(DW'($urandom));
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          p0, sel;
    logic [7:0]  bad;
    repeat (3) @(negedge clk);
    check("reset_miso", {31'b0, spi_miso}, 32'd0);
    check("reset_oe", {31'b0, spi_miso_oe}, 32'd0);
    check("reset_odstart", {31'b0, buf_odstart}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    asyn_resetn = 1'b1;
    repeat (6) @(negedge clk);

    // Status read with raw interrupt only.
    do_status(1'b1, 1'b0, 1);

    // Two-word burst, then a single word 000001 (parity bit 0 when enabled).
    buf_q.delete();
    buf_q.push_back(24'h123456);
    buf_q.push_back(24'hABCDEF);
    buf_q.push_back(24'h000001);
    do_read(2, 1'b1, 1'b0);
    do_read(1, 1'b1, 1'b0);

    // No interrupt: buffer shows zeros, no strobes.
    refill(3);
    do_read(1, 1'b0, 1'b0);

    // Unknown command.
    do_bad(8'h3C, 2);

    // Abort after 10 data bits, then a clean read gets the next word.
    refill(4);
    buf_int_raw = 1'b1; buf_int_peak = 1'b0;
    repeat (2) @(negedge clk);
    p0 = od_pulses;
    spi_clock(CMD_READ_DEFAULT, 10, 1'b1);
    repeat (SYNC + 4) @(negedge clk);
    check("abort_odstart_count", 32'(od_pulses - p0), 32'd1);
    check("abort_oe", {31'b0, spi_miso_oe}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_miso", {31'b0, spi_miso}, 32'd0);
    $display("abort  pulses=%0d", od_pulses - p0);
    do_read(1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a data word.
    refill(4);
    p0 = od_pulses;
    spi_clock(CMD_READ_DEFAULT, 10, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_busy_before", {31'b0, busy}, 32'd1);
    asyn_resetn = 1'b0;
    #1;
    check("rst_miso", {31'b0, spi_miso}, 32'd0);
    check("rst_oe", {31'b0, spi_miso_oe}, 32'd0);
    check("rst_odstart", {31'b0, buf_odstart}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    spi_csn = 1'b1;
    repeat (4) @(negedge clk);
    asyn_resetn = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_odstart_count", 32'(od_pulses - p0), 32'd1);
    $display("reset  mid-word pulses=%0d", od_pulses - p0);

    // Randomized mix of transactions.
    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        refill(5);
        do_read($urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (sel == 1) begin
        do_status(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 2));
      end else begin
        bad = 8'($urandom);
        if (bad == CMD_READ_DEFAULT || bad == CMD_STATUS_DEFAULT) bad = 8'h00;
        do_bad(bad, $urandom_range(1, 2));
      end
    end

    check("final_frames_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_readout_tx.md
Name: spi_readout_tx

Overview:
- SPI target (mode 0: CPOL=0, CPHA=0) that serializes 24-bit result words from the TDC input buffer onto MISO for the external host.
- Sits at the far end of the buffer's output interface. It samples the buffer's 24-bit output word and pulses the advance strobe once per word it loads.
- SPI pins are oversampled in the clk domain. clk must be at least 8x SCLK.
- The host reads status or data with a 1-byte command, then clocks out data.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for spi_csn, spi_sclk and spi_mosi (minimum 2).
- DW, 24, data word width taken from the buffer.
- CMD_READ, 8'hA5, command byte that starts a burst of data-word reads.
- CMD_STATUS, 8'h0F, command byte that returns the status byte.

Ports:
- clk  input  1  system clock.
- asyn_resetn  input  1  reset, asynchronous, active-low; clock clk.
- spi_csn  input  1  chip select, active low, asynchronous to clk.
- spi_sclk  input  1  serial clock from host, asynchronous to clk.
- spi_mosi  input  1  host-to-target data, MSB first.
- spi_miso  output  1  target-to-host data, MSB first.
- spi_miso_oe  output  1  MISO output enable; high only while CS is synchronized low.
- buf_data  input  DW  current output word from the buffer.
- buf_int_raw  input  1  buffer holds raw words.
- buf_int_peak  input  1  buffer holds a histogram/peak word.
- buf_odstart  output  1  one-clk advance strobe to the buffer.
- busy  output  1  high while a transaction is active.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, buf_odstart=0, busy=0, FSM=IDLE, all counters and shift registers 0.
- Synchronization: each SPI input passes through SYNC_STAGES flops. Edges are detected on the last two stages. Pin-to-internal-event latency is SYNC_STAGES+1 clk.
- FSM states: IDLE, CMD, STAT, DATA, DRAIN.
- IDLE -> CMD on synchronized CS falling edge. bit_cnt is cleared; spi_miso_oe=1 and busy=1 take effect that same cycle.
- CMD: shift MOSI into cmd_sr on each SCLK rising edge, MSB first. On the 8th rising edge, decode the byte. The next state and the load happen on the following SCLK falling edge.
  - Byte equals CMD_STATUS -> STAT; load {6'b0, buf_int_peak, buf_int_raw}.
  - Byte equals CMD_READ -> DATA; load buf_data.
  - Any other byte -> DRAIN.
- MISO timing: MISO updates only on synchronized SCLK falling edges, always driving shift register MSB. MISO is 0 during CMD.
- STAT: shift out 8 bits, then drive 0 until CS rises. buf_odstart is never pulsed in STAT.
- DATA:
  - At each word load, capture buf_data into a DW-bit shift register. On the clk cycle after the capture, pulse buf_odstart for exactly 1 clk, but only if (buf_int_raw | buf_int_peak) was sampled high at capture.
  - After DW falling edges, the next word loads on the same falling edge; the burst length is unbounded.
  - If no interrupt was high at capture, the word loads normally (the buffer presents zeros) and buf_odstart is not pulsed.
- DRAIN: MISO=0, no strobes.
- CS rising edge in any state: return to IDLE next clk; spi_miso_oe=0, busy=0, spi_miso=0.
  - A partially shifted word is discarded. Its advance strobe has already been issued and is not retracted.
  - An odstart scheduled for the same clk as CS rise is still issued.
- CS high while SCLK toggles: ignored. A CS glitch shorter than SYNC_STAGES+1 clk may be missed; this is defined behaviour.
- Async reset mid-transaction: immediate return to reset values; the host must re-issue the command.
- Counters: bit_cnt is 5 bits and wraps at DW (or DW+1 with parity enabled). No overflow is possible.

Optional Feature:
- Macro: SPI_PARITY_EN.
- Defined: each DATA word frame is DW+1 bits. The word is followed by an odd-parity bit over the DW data bits, so frames are 25 bits by default. The next load occurs after the parity bit. STAT is unaffected.
- Undefined: frames are exactly DW bits, with no parity logic.

Decomposition:
- Shared package spi_pkg:
  - typedef enum for the FSM states;
  - CMD_READ and CMD_STATUS default localparams;
  - STATUS_W = 8.
- One sub-module: spi_in_sync, a parameterized SYNC_STAGES-deep synchronizer with rise/fall pulse outputs. It is instantiated once each for CS, SCLK and MOSI; MOSI uses the level output only.

Test Plan:
- Status read: buf_int_raw=1, buf_int_peak=0; host sends 8'h0F then 8 clocks -> host reads 8'h01; buf_odstart never pulses.
- Data burst: buf_int_raw=1; the buffer model presents 24'h123456, then 24'hABCDEF after each strobe; host sends 8'hA5 then 48 clocks -> reads 24'h123456 then 24'hABCDEF; exactly 2 single-clk odstart pulses.
- No interrupt: both interrupts low; host sends 8'hA5 plus 24 clocks -> reads 24'h000000 (buffer zeros); 0 odstart pulses.
- Bad command: host sends 8'h3C plus 16 clocks -> MISO stays 0; 0 strobes; busy drops within SYNC_STAGES+2 clk of CS rise.
- Abort: CS rises after 10 data bits -> FSM in IDLE; spi_miso_oe=0; exactly 1 odstart pulse logged. The next 8'hA5 transaction starts cleanly with the new word.
- Reset mid-word: asyn_resetn asserted during DATA -> all outputs at reset values immediately. With SPI_PARITY_EN defined, word 24'h000001 is followed by parity bit 0 (odd parity over one 1 bit).
